// File: rtl/w0rm_alu_pkg.sv
// Shared ALU constants: flag bit positions, buffer occupancy states,
// opcode encodings and the masked flag-merge helper.
package w0rm_alu_pkg;

    localparam int FLAG_W     = 4;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVER  = 2;
    localparam int FLAG_CARRY = 3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_CMP = 4'd7
    } alu_op_e;

    // Bits selected by mask take the new value, the rest keep the current one.
    function automatic logic [FLAG_W-1:0] flag_merge(
        input logic [FLAG_W-1:0] cur,
        input logic [FLAG_W-1:0] nw,
        input logic [FLAG_W-1:0] mask
    );
        return (cur & ~mask) | (nw & mask);
    endfunction

endpackage

// File: rtl/w0rm_core_alu_wb_fifo.sv
// Two-entry in-order buffer with 1-bit pointers. Besides the current head
// it exposes the head that will be present after this edge, so the owner
// can register head-derived outputs without a bubble.
module w0rm_core_alu_wb_fifo
    import w0rm_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] nxt_head_o,
    output logic             nxt_nonempty_o,
    output logic             empty_o,
    output logic             full_o
);

    occ_e             state_q, state_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [2];

    // Occupancy and pointer next-state; flush wins over push/pop.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush_i) begin
            state_d = OCC_EMPTY;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
        end else begin
            if (push_i) wr_d = ~wr_q;
            if (pop_i)  rd_d = ~rd_q;
            case (state_q)
                OCC_EMPTY: if (push_i) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (push_i && !pop_i)      state_d = OCC_FULL;
                    else if (!push_i && pop_i) state_d = OCC_EMPTY;
                end
                OCC_FULL:  if (pop_i && !push_i) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Entry storage; push is never asserted while full or flushing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign head_o = mem_q[rd_q];
    // The slot being written this edge becomes head when it is where rd lands.
    assign nxt_head_o     = (push_i && (wr_q == rd_d)) ? din_i : mem_q[rd_d];
    assign nxt_nonempty_o = (state_d != OCC_EMPTY);
    assign empty_o        = (state_q == OCC_EMPTY);
    assign full_o         = (state_q == OCC_FULL);

endmodule

// File: rtl/w0rm_core_alu_writeback.sv
// ALU writeback stage: buffers up to two results, issues registered
// register-file writes in order and commits masked flags on retire.
module w0rm_core_alu_writeback
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [FLAG_W-1:0]         in_flags,
    input  logic [FLAG_W-1:0]         in_flags_mask,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest_reg,
    input  logic                      in_write_reg,
    input  logic                      flush,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [FLAG_W-1:0]         flags,
    output logic                      busy
);

    // Entry layout, LSB first: write_reg, dest, mask, flags, result.
    localparam int DST_LO = 1;
    localparam int MSK_LO = DST_LO + REG_ADDR_WIDTH;
    localparam int FLG_LO = MSK_LO + FLAG_W;
    localparam int RES_LO = FLG_LO + FLAG_W;
    localparam int EW     = RES_LO + DATA_WIDTH;

    logic [EW-1:0]             din, head, nxt_head;
    logic                      nxt_nonempty, empty, full;
    logic                      accept, retire;
    logic                      wb_valid_q, wb_valid_d;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [FLAG_W-1:0]         flags_q, flags_d;
    logic                      unused_head;

    assign din = {in_result, in_flags, in_flags_mask, in_dest_reg, in_write_reg};

    assign in_ready = !full && !flush;
    assign accept   = in_valid && in_ready;
    // Write heads wait for the handshake; flags-only heads leave immediately.
    assign retire   = !empty && !flush && (head[0] ? (wb_valid_q && wb_ready) : 1'b1);

    w0rm_core_alu_wb_fifo #(.WIDTH(EW)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (accept),
        .pop_i         (retire),
        .flush_i       (flush),
        .din_i         (din),
        .head_o        (head),
        .nxt_head_o    (nxt_head),
        .nxt_nonempty_o(nxt_nonempty),
        .empty_o       (empty),
        .full_o        (full)
    );

    // Next write request mirrors the head that exists after this edge.
    always_comb begin
        wb_valid_d = nxt_nonempty && nxt_head[0];
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (wb_valid_d) begin
            wb_addr_d = nxt_head[MSK_LO-1:DST_LO];
            wb_data_d = nxt_head[EW-1:RES_LO];
        end
        flags_d = flags_q;
        if (retire) flags_d = flag_merge(flags_q, head[RES_LO-1:FLG_LO], head[FLG_LO-1:MSK_LO]);
    end

    // Writeback and architectural flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
        end
    end

    // Head result/dest are consumed through the registered wb path instead.
    assign unused_head = ^{head[EW-1:RES_LO], head[MSK_LO-1:DST_LO]};

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;
    assign busy     = !empty;

endmodule
